// File: rtl/ram_1r1w_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_1r1w_arbiter_if
// Brief   : Client request/response bundle plus RAM-side port for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface ram_1r1w_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 16
);
   logic [1:0]      wr_valid;
   logic [1:0]      wr_ready;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic [1:0]      rd_valid;
   logic [1:0]      rd_ready;
   logic [2*AW-1:0] rd_addr;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            ram_ena;
   logic [AW-1:0]   ram_addra;
   logic [DW-1:0]   ram_dia;
   logic            ram_enb;
   logic [AW-1:0]   ram_addrb;
   logic [DW-1:0]   ram_dob;

   // Clients plus the RAM instance on one side.
   modport master (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dob,
      input  wr_ready, rd_ready, rsp_valid, rsp_data,
      input  ram_ena, ram_addra, ram_dia, ram_enb, ram_addrb
   );

   // The arbiter itself.
   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dob,
      output wr_ready, rd_ready, rsp_valid, rsp_data,
      output ram_ena, ram_addra, ram_dia, ram_enb, ram_addrb
   );
endinterface
`default_nettype wire

// File: rtl/ram_1r1w_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_1r1w_arbiter
// Brief   : Two-client round-robin arbiter for a 1R1W RAM with tagged reads.
// Revision: 1.0 - initial release
// ============================================================================
module ram_1r1w_arbiter #(
   parameter int AW     = 10,
   parameter int DW     = 16,
   parameter int BYPASS = 1
) (
   input  logic               clk,
   input  logic               rst,
   ram_1r1w_arbiter_if.slave  bus
);
   localparam bit c_bypass_en = (BYPASS != 0);

   logic          r_wptr;
   logic          r_rptr;
   logic [1:0]    r_rsp_tag;
   logic          r_byp_sel;
   logic [DW-1:0] r_byp_data;

   logic [1:0]    w_wr_gnt;
   logic [1:0]    w_rd_gnt;
   logic          w_coll;

   // Grants are gated by rst so nothing is accepted during a reset cycle.
   always_comb begin
      w_wr_gnt = 2'b00;
      w_rd_gnt = 2'b00;
      if (!rst) begin
         w_wr_gnt[0] = bus.wr_valid[0] & (~bus.wr_valid[1] | ~r_wptr);
         w_wr_gnt[1] = bus.wr_valid[1] & (~bus.wr_valid[0] |  r_wptr);
         w_rd_gnt[0] = bus.rd_valid[0] & (~bus.rd_valid[1] | ~r_rptr);
         w_rd_gnt[1] = bus.rd_valid[1] & (~bus.rd_valid[0] |  r_rptr);
      end
   end

   assign bus.wr_ready = w_wr_gnt;
   assign bus.rd_ready = w_rd_gnt;
   assign bus.ram_ena  = |(bus.wr_valid & w_wr_gnt);
   assign bus.ram_enb  = |(bus.rd_valid & w_rd_gnt);

   always_comb begin
      bus.ram_addra = '0;
      bus.ram_dia   = '0;
      bus.ram_addrb = '0;
      if (w_wr_gnt[0]) begin
         bus.ram_addra = bus.wr_addr[0 +: AW];
         bus.ram_dia   = bus.wr_data[0 +: DW];
      end else if (w_wr_gnt[1]) begin
         bus.ram_addra = bus.wr_addr[AW +: AW];
         bus.ram_dia   = bus.wr_data[DW +: DW];
      end
      if (w_rd_gnt[0]) begin
         bus.ram_addrb = bus.rd_addr[0 +: AW];
      end else if (w_rd_gnt[1]) begin
         bus.ram_addrb = bus.rd_addr[AW +: AW];
      end
   end

   assign w_coll = bus.ram_ena & bus.ram_enb & (bus.ram_addra == bus.ram_addrb);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_rsp_tag  <= 2'b00;
         r_byp_sel  <= 1'b0;
         r_byp_data <= '0;
      end else begin
         if (&bus.wr_valid) r_wptr <= ~r_wptr;
         if (&bus.rd_valid) r_rptr <= ~r_rptr;
         r_rsp_tag  <= w_rd_gnt;
         r_byp_sel  <= c_bypass_en & w_coll;
         r_byp_data <= bus.ram_dia;
      end
   end

   // Response lines up with the RAM's one-cycle registered read.
   assign bus.rsp_valid = r_rsp_tag;
   assign bus.rsp_data  = r_byp_sel ? r_byp_data : bus.ram_dob;
endmodule
`default_nettype wire

// File: tb/tb_ram_1r1w_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_1r1w_arbiter
// Brief   : Directed bench for ram_1r1w_arbiter, BYPASS=1 and BYPASS=0 copies.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_1r1w_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] mem0 [1024];
   logic [15:0] mem1 [1024];

   ram_1r1w_arbiter_if #(.AW(10), .DW(16)) if0 ();
   ram_1r1w_arbiter_if #(.AW(10), .DW(16)) if1 ();

   ram_1r1w_arbiter #(.AW(10), .DW(16), .BYPASS(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   ram_1r1w_arbiter #(.AW(10), .DW(16), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   // Read-before-write RAM models with a registered read port.
   always @(posedge clk) begin
      if (if0.ram_ena) mem0[if0.ram_addra] <= if0.ram_dia;
      if (if0.ram_enb) if0.ram_dob <= mem0[if0.ram_addrb];
      if (if1.ram_ena) mem1[if1.ram_addra] <= if1.ram_dia;
      if (if1.ram_enb) if1.ram_dob <= mem1[if1.ram_addrb];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_wr(input logic [1:0] v, input logic [9:0] a1, input logic [9:0] a0,
                         input logic [15:0] d1, input logic [15:0] d0);
      if0.wr_valid = v; if0.wr_addr = {a1, a0}; if0.wr_data = {d1, d0};
      if1.wr_valid = v; if1.wr_addr = {a1, a0}; if1.wr_data = {d1, d0};
   endtask

   task automatic drv_rd(input logic [1:0] v, input logic [9:0] a1, input logic [9:0] a0);
      if0.rd_valid = v; if0.rd_addr = {a1, a0};
      if1.rd_valid = v; if1.rd_addr = {a1, a0};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drv_wr(2'b11, 10'd1, 10'd2, 16'h1, 16'h2);
      drv_rd(2'b11, 10'd1, 10'd2);
      tick();
      tick();
      #1;
      checks++; if (if0.wr_ready !== 2'b00) begin errors++; $display("FAIL reset_wr_ready got %b want 00", if0.wr_ready); end
      checks++; if (if0.rd_ready !== 2'b00) begin errors++; $display("FAIL reset_rd_ready got %b want 00", if0.rd_ready); end
      checks++; if (if0.ram_ena !== 1'b0) begin errors++; $display("FAIL reset_ram_ena got %b want 0", if0.ram_ena); end
      checks++; if (if0.ram_enb !== 1'b0) begin errors++; $display("FAIL reset_ram_enb got %b want 0", if0.ram_enb); end
      checks++; if (if0.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", if0.rsp_valid); end
      drv_wr(2'b00, 10'd0, 10'd0, 16'h0, 16'h0);
      drv_rd(2'b00, 10'd0, 10'd0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_basic();
      tick();
      drv_wr(2'b01, 10'd0, 10'd5, 16'h0, 16'hBEEF);
      #1;
      checks++; if (if0.wr_ready !== 2'b01) begin errors++; $display("FAIL basic_wr_ready got %b want 01", if0.wr_ready); end
      checks++; if (if0.ram_ena !== 1'b1 || if0.ram_addra !== 10'd5 || if0.ram_dia !== 16'hBEEF) begin
         errors++; $display("FAIL basic_ram_wr got ena=%b addr=%0d data=%h want 1/5/beef", if0.ram_ena, if0.ram_addra, if0.ram_dia); end
      tick();
      drv_wr(2'b00, 10'd0, 10'd0, 16'h0, 16'h0);
      drv_rd(2'b10, 10'd5, 10'd0);
      #1;
      checks++; if (if0.rd_ready !== 2'b10 || if0.ram_addrb !== 10'd5) begin
         errors++; $display("FAIL basic_rd_grant got ready=%b addr=%0d want 10/5", if0.rd_ready, if0.ram_addrb); end
      tick();
      drv_rd(2'b00, 10'd0, 10'd0);
      #1;
      checks++; if (if0.rsp_valid !== 2'b10 || if0.rsp_data !== 16'hBEEF) begin
         errors++; $display("FAIL basic_rsp got valid=%b data=%h want 10/beef", if0.rsp_valid, if0.rsp_data); end
      checks++; if (if1.rsp_valid !== 2'b10 || if1.rsp_data !== 16'hBEEF) begin
         errors++; $display("FAIL basic_rsp_nb got valid=%b data=%h want 10/beef", if1.rsp_valid, if1.rsp_data); end
      tick();
      #1;
      checks++; if (if0.rsp_valid !== 2'b00) begin errors++; $display("FAIL basic_rsp_once got %b want 00", if0.rsp_valid); end
   endtask

   task automatic test_write_fairness();
      int n0 = 0;
      int n1 = 0;
      logic [1:0] exp_g;
      drv_wr(2'b11, 10'd200, 10'd100, 16'hB200, 16'hA100);
      for (int i = 0; i < 6; i++) begin
         #1;
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         checks++; if (if0.wr_ready !== exp_g || if0.ram_addra !== ((i % 2 == 0) ? 10'd100 : 10'd200)) begin
            errors++; $display("FAIL wr_fair_%0d got ready=%b addr=%0d want %b", i, if0.wr_ready, if0.ram_addra, exp_g); end
         if (if0.wr_ready == 2'b01) n0++;
         if (if0.wr_ready == 2'b10) n1++;
         tick();
      end
      drv_wr(2'b00, 10'd0, 10'd0, 16'h0, 16'h0);
      checks++; if (n0 !== 3 || n1 !== 3) begin errors++; $display("FAIL wr_fair_count got r0=%0d r1=%0d want 3/3", n0, n1); end
   endtask

   task automatic test_read_fairness();
      drv_rd(2'b10, 10'd200, 10'd0);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (if0.rd_ready !== 2'b10) begin errors++; $display("FAIL rd_single_grant_%0d got %b want 10", i, if0.rd_ready); end
         if (i > 0) begin
            checks++; if (if0.rsp_valid !== 2'b10 || if0.rsp_data !== 16'hB200) begin
               errors++; $display("FAIL rd_single_rsp_%0d got valid=%b data=%h want 10/b200", i, if0.rsp_valid, if0.rsp_data); end
         end
         tick();
      end
      drv_rd(2'b11, 10'd200, 10'd100);
      #1;
      checks++; if (if0.rd_ready !== 2'b01 || if0.rsp_valid !== 2'b10) begin
         errors++; $display("FAIL rd_both_first got ready=%b rsp=%b want 01/10", if0.rd_ready, if0.rsp_valid); end
      tick();
      #1;
      checks++; if (if0.rd_ready !== 2'b10 || if0.rsp_valid !== 2'b01 || if0.rsp_data !== 16'hA100) begin
         errors++; $display("FAIL rd_both_second got ready=%b rsp=%b data=%h want 10/01/a100", if0.rd_ready, if0.rsp_valid, if0.rsp_data); end
      tick();
      drv_rd(2'b00, 10'd0, 10'd0);
      #1;
      checks++; if (if0.rsp_valid !== 2'b10 || if0.rsp_data !== 16'hB200) begin
         errors++; $display("FAIL rd_both_rsp got valid=%b data=%h want 10/b200", if0.rsp_valid, if0.rsp_data); end
      tick();
   endtask

   task automatic test_collision();
      drv_wr(2'b01, 10'd0, 10'd9, 16'h0, 16'h1111);
      tick();
      drv_wr(2'b01, 10'd0, 10'd9, 16'h0, 16'h2222);
      drv_rd(2'b10, 10'd9, 10'd0);
      #1;
      checks++; if (if0.wr_ready !== 2'b01 || if0.rd_ready !== 2'b10) begin
         errors++; $display("FAIL coll_grant got wr=%b rd=%b want 01/10", if0.wr_ready, if0.rd_ready); end
      tick();
      drv_wr(2'b00, 10'd0, 10'd0, 16'h0, 16'h0);
      drv_rd(2'b00, 10'd0, 10'd0);
      #1;
      checks++; if (if0.rsp_valid !== 2'b10 || if0.rsp_data !== 16'h2222) begin
         errors++; $display("FAIL coll_bypass got valid=%b data=%h want 10/2222", if0.rsp_valid, if0.rsp_data); end
      checks++; if (if1.rsp_valid !== 2'b10 || if1.rsp_data !== 16'h1111) begin
         errors++; $display("FAIL coll_nobypass got valid=%b data=%h want 10/1111", if1.rsp_valid, if1.rsp_data); end
      tick();
      drv_rd(2'b10, 10'd9, 10'd0);
      tick();
      drv_rd(2'b00, 10'd0, 10'd0);
      #1;
      checks++; if (if1.rsp_data !== 16'h2222 || if0.rsp_data !== 16'h2222) begin
         errors++; $display("FAIL coll_reread got nb=%h byp=%h want 2222/2222", if1.rsp_data, if0.rsp_data); end
      tick();
   endtask

   task automatic test_reset_midstream();
      drv_rd(2'b11, 10'd200, 10'd100);
      #1;
      checks++; if (if0.rd_ready !== 2'b01) begin errors++; $display("FAIL mid_c1 got %b want 01", if0.rd_ready); end
      tick();
      #1;
      checks++; if (if0.rd_ready !== 2'b10) begin errors++; $display("FAIL mid_c2 got %b want 10", if0.rd_ready); end
      tick();
      #1;
      checks++; if (if0.rd_ready !== 2'b01) begin errors++; $display("FAIL mid_c3 got %b want 01", if0.rd_ready); end
      tick();
      rst = 1'b1;
      #1;
      checks++; if (if0.rd_ready !== 2'b00 || if0.ram_enb !== 1'b0) begin
         errors++; $display("FAIL mid_rst1_grant got ready=%b enb=%b want 00/0", if0.rd_ready, if0.ram_enb); end
      checks++; if (if0.rsp_valid !== 2'b01 || if0.rsp_data !== 16'hA100) begin
         errors++; $display("FAIL mid_rst1_rsp got valid=%b data=%h want 01/a100", if0.rsp_valid, if0.rsp_data); end
      tick();
      #1;
      checks++; if (if0.rd_ready !== 2'b00 || if0.rsp_valid !== 2'b00) begin
         errors++; $display("FAIL mid_rst2 got ready=%b rsp=%b want 00/00", if0.rd_ready, if0.rsp_valid); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (if0.rsp_valid !== 2'b00 || if0.rd_ready !== 2'b01) begin
         errors++; $display("FAIL mid_after got rsp=%b ready=%b want 00/01", if0.rsp_valid, if0.rd_ready); end
      tick();
      drv_rd(2'b00, 10'd0, 10'd0);
      #1;
      checks++; if (if0.rsp_valid !== 2'b01 || if0.rsp_data !== 16'hA100) begin
         errors++; $display("FAIL mid_after_rsp got valid=%b data=%h want 01/a100", if0.rsp_valid, if0.rsp_data); end
      tick();
   endtask

   initial begin
      drv_wr(2'b00, 10'd0, 10'd0, 16'h0, 16'h0);
      drv_rd(2'b00, 10'd0, 10'd0);
      test_reset();
      test_basic();
      test_write_fairness();
      test_read_fairness();
      test_collision();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
